// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: constants and helpers shared by the LED PWM array and its
// per-channel slices.
//   DEF_*        default parameter values for led_pwm_array
//   MAX_DUTY_W   widest duty/phase counter the helpers accept
//   fade_dir_e   direction of one fade step
//   fade_dir()   which way active must move to approach target
package led_pwm_pkg;

  localparam int DEF_CHANNELS = 3;
  localparam int DEF_DUTY_W   = 8;
  localparam int DEF_PRESCALE = 32;
  localparam int DEF_FADE_EN  = 1;
  localparam int MAX_DUTY_W   = 12;

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_UP,
    DIR_DOWN
  } fade_dir_e;

  // Operands arrive zero-extended to MAX_DUTY_W, so any DUTY_W up to
  // MAX_DUTY_W shares this one helper.
  function automatic fade_dir_e fade_dir(input logic [MAX_DUTY_W-1:0] active,
                                         input logic [MAX_DUTY_W-1:0] target);
    if (active < target) return DIR_UP;
    if (active > target) return DIR_DOWN;
    return DIR_HOLD;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel. It holds the written target, the duty
// currently being displayed (active), the pending/fade flags and the PWM
// comparator. It updates active only at period boundaries, so a period
// never shows a mix of two duties.
//   clock_100mhz, reset  clock, async active-high reset
//   enable               low forces led off on the next edge
//   boundary             tick that ends the last phase of a period
//   next_phase           phase value that takes effect on the coming edge
//   wr_en                accepted write addressed to this channel
//   wr_duty, wr_fade     write payload
//   pending              a write waits for the next boundary
//   led                  registered PWM output
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int FADE_EN = DEF_FADE_EN
) (
  input  logic              clock_100mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] next_phase,
  input  logic              wr_en,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              wr_fade,
  output logic              pending,
  output logic              led
);

  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] active;
  logic              fading;
  logic              fade_req;

  logic [DUTY_W-1:0] active_d;
  logic              fading_d;

  // NOTE: every variable gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    active_d = active;
    fading_d = fading;
    if (boundary) begin
      if (pending && !fade_req) begin
        active_d = target;
        fading_d = 1'b0;
      end else if (pending || fading) begin
        // A new fade write takes its first step at this same boundary.
        unique case (fade_dir(MAX_DUTY_W'(active), MAX_DUTY_W'(target)))
          DIR_UP:   active_d = active + DUTY_W'(1);
          DIR_DOWN: active_d = active - DUTY_W'(1);
          default:  active_d = active;
        endcase
        fading_d = (active_d != target);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, regardless of statement order.
  // NOTE: all state here is a small set of flops, so every register gets the
  // async reset; nothing is left to power-up values.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      target   <= '0;
      active   <= '0;
      fading   <= 1'b0;
      fade_req <= 1'b0;
      pending  <= 1'b0;
      led      <= 1'b0;
    end else begin
      active <= active_d;
      fading <= fading_d;
      // Comparing with the post-edge phase and duty keeps led in step with
      // the phase counter, including the first cycle of a new period.
      led    <= enable && (next_phase < active_d);
      // A write is only accepted while pending is clear. The boundary above
      // therefore always works on the pre-write state.
      if (wr_en) begin
        target   <= wr_duty;
        fade_req <= wr_fade && (FADE_EN != 0);
        pending  <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_pwm_array.sv
// led_pwm_array: CHANNELS independent PWM LED drivers that share one
// prescaler and one phase counter. Writes are queued per channel and
// applied at the next period boundary, either as a jump or as a
// one-step-per-period fade.
//   clock_100mhz, reset  clock, async active-high reset
//   enable               low forces all led outputs off
//   wr_valid/wr_ready    duty write handshake
//   wr_channel           target channel (out-of-range writes are dropped)
//   wr_duty, wr_fade     new target duty, ramp (1) or jump (0)
//   led                  registered PWM outputs, one per channel
//   period_start         one-cycle pulse in the first cycle of phase 0
module led_pwm_array
  import led_pwm_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int DUTY_W   = DEF_DUTY_W,
  parameter  int PRESCALE = DEF_PRESCALE,
  parameter  int FADE_EN  = DEF_FADE_EN,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                clock_100mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_channel,
  input  logic [DUTY_W-1:0]   wr_duty,
  input  logic                wr_fade,
  output logic [CHANNELS-1:0] led,
  output logic                period_start
);

  logic [PW-1:0]       presc;
  logic [DUTY_W-1:0]   phase;
  logic [DUTY_W-1:0]   next_phase;
  logic                tick;
  logic                boundary;
  logic [CHANNELS-1:0] pending;
  logic                pend_sel;
  logic                wr_accept;

  assign tick       = (presc == PW'(PRESCALE - 1));
  assign boundary   = tick && (phase == '1);
  assign next_phase = tick ? phase + DUTY_W'(1) : phase;

  // The decode loop leaves pend_sel at 0 for channel numbers that do not
  // exist. Such writes then see wr_ready high and are dropped, because no
  // channel matches.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_channel == CW'(i)) pend_sel = pending[i];
    end
  end

  assign wr_ready  = !reset && !pend_sel;
  assign wr_accept = wr_valid && wr_ready;

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      phase        <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + PW'(1);
      phase        <= next_phase;
      period_start <= boundary;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pwm_channel #(
      .DUTY_W  (DUTY_W),
      .FADE_EN (FADE_EN)
    ) u_ch (
      .clock_100mhz (clock_100mhz),
      .reset        (reset),
      .enable       (enable),
      .boundary     (boundary),
      .next_phase   (next_phase),
      .wr_en        (wr_accept && (wr_channel == CW'(i))),
      .wr_duty      (wr_duty),
      .wr_fade      (wr_fade),
      .pending      (pending[i]),
      .led          (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// tb_led_pwm_array: directed, table-driven bench for led_pwm_array with
// CHANNELS=3, DUTY_W=4, PRESCALE=4 (64 clocks per PWM period). Duty is
// observed as the number of led-high cycles per period (4 per duty step).
// Those highs must also sit at the start of the period.
module tb_led_pwm_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_channel;
  logic [3:0] wr_duty;
  logic       wr_fade;
  logic [2:0] led;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pwm_array #(
    .CHANNELS (3),
    .DUTY_W   (4),
    .PRESCALE (4),
    .FADE_EN  (1)
  ) dut (
    .clock_100mhz (clk),
    .reset        (reset),
    .enable       (enable),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_channel   (wr_channel),
    .wr_duty      (wr_duty),
    .wr_fade      (wr_fade),
    .led          (led),
    .period_start (period_start)
  );

  typedef struct {
    int ch;
    int duty;
    int fade;
    int e0;
    int e1;
    int e2;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next negedge where period_start is high (bounded).
  task automatic wait_ps(input string name);
    int found = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1;
        break;
      end
    end
    check({name, " period_start seen"}, found, 1);
  endtask

  // Caller stands on the negedge of the first cycle of a period.
  task automatic measure_here(input int e0, input int e1, input int e2,
                              input string name);
    int hi[3];
    int early[3];
    int ex[3];
    ex = '{e0, e1, e2};
    for (int c = 0; c < 3; c++) begin
      hi[c] = 0;
      early[c] = 0;
    end
    check({name, " period_start"}, int'(period_start), 1);
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (led[c]) begin
          hi[c]++;
          if (k < ex[c]) early[c]++;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s hi ch%0d", name, c), hi[c], ex[c]);
      check($sformatf("%s lead ch%0d", name, c), early[c], ex[c]);
    end
  endtask

  task automatic measure(input int e0, input int e1, input int e2,
                         input string name);
    wait_ps(name);
    measure_here(e0, e1, e2, name);
  endtask

  // Called on a negedge; the write is presented for exactly one posedge.
  task automatic do_write(input int ch, input int duty, input int fade);
    wr_channel = 2'(ch);
    wr_duty    = 4'(duty);
    wr_fade    = 1'(fade);
    wr_valid   = 1'b1;
    @(negedge clk);
    wr_valid   = 1'b0;
  endtask

  task automatic apply(input int ch, input int duty, input int fade,
                       input string name);
    wait_ps(name);
    do_write(ch, duty, fade);
  endtask

  task automatic check_ready(input int ch, input int exp, input string name);
    wr_channel = 2'(ch);
    #1;
    check(name, int'(wr_ready), exp);
  endtask

  task automatic count_to_ps(input string name);
    int n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (period_start) begin
        n = k;
        break;
      end
    end
    check(name, n, 64);
  endtask

  initial begin
    vecs[0] = '{ch: 0, duty: 4,  fade: 0, e0: 16, e1: 0,  e2: 0};
    vecs[1] = '{ch: 1, duty: 0,  fade: 0, e0: 16, e1: 0,  e2: 0};
    vecs[2] = '{ch: 2, duty: 15, fade: 0, e0: 16, e1: 0,  e2: 60};
    vecs[3] = '{ch: 0, duty: 1,  fade: 0, e0: 4,  e1: 0,  e2: 60};
    vecs[4] = '{ch: 1, duty: 8,  fade: 0, e0: 4,  e1: 32, e2: 60};

    reset      = 1'b1;
    enable     = 1'b1;
    wr_valid   = 1'b0;
    wr_channel = '0;
    wr_duty    = '0;
    wr_fade    = 1'b0;

    // Reset state and release timing.
    repeat (3) @(negedge clk);
    check("rst led", int'(led), 0);
    check("rst period_start", int'(period_start), 0);
    check("rst wr_ready", int'(wr_ready), 0);
    reset = 1'b0;
    #1;
    check("release wr_ready", int'(wr_ready), 1);
    count_to_ps("release to first period_start");

    // Jump writes: duty 4, 0, 15 and others, each measured on its own period.
    for (int v = 0; v < 5; v++) begin
      apply(vecs[v].ch, vecs[v].duty, vecs[v].fade, $sformatf("vec%0d", v));
      measure(vecs[v].e0, vecs[v].e1, vecs[v].e2, $sformatf("vec%0d", v));
    end

    // Fade ch0 0 -> 3 one step per period, hold, then fade down to 1.
    apply(0, 0, 0, "fade pre");
    measure(0, 32, 60, "fade pre");
    apply(0, 3, 1, "fade up");
    measure(4, 32, 60, "fade up1");
    measure(8, 32, 60, "fade up2");
    measure(12, 32, 60, "fade up3");
    measure(12, 32, 60, "fade hold");
    apply(0, 1, 1, "fade down");
    measure(8, 32, 60, "fade down1");
    measure(4, 32, 60, "fade down2");
    measure(4, 32, 60, "fade down3");

    // Pending handshake: ch1 blocked until the boundary, ch2/ch3 are not.
    wait_ps("pend");
    do_write(1, 2, 0);
    check_ready(1, 0, "pend ch1 blocked");
    do_write(1, 13, 0);
    check_ready(2, 1, "pend ch2 ready");
    do_write(2, 5, 0);
    check_ready(3, 1, "pend ch3 ready");
    do_write(3, 9, 0);
    check_ready(1, 0, "pend ch1 still blocked");
    wait_ps("pend boundary");
    check_ready(1, 1, "pend ch1 freed");
    measure_here(4, 8, 20, "pend");

    // Write landing exactly on the boundary edge: old duty holds a period.
    check_ready(2, 1, "edge ch2 ready");
    wr_duty  = 4'd10;
    wr_fade  = 1'b0;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    measure_here(4, 8, 20, "edge old");
    measure(4, 8, 40, "edge new");

    // enable low blanks the outputs; counters keep running.
    wait_ps("enable");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("enable off led", int'(led), 0);
    repeat (5) @(negedge clk);
    check("enable off led later", int'(led), 0);
    enable = 1'b1;
    measure(4, 8, 40, "enable back");

    // Reset in the middle of a fade.
    apply(0, 15, 1, "rst fade");
    measure(8, 8, 40, "rst fade1");
    measure(12, 8, 40, "rst fade2");
    wait_ps("rst mid");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid rst led async", int'(led), 0);
    check("mid rst wr_ready", int'(wr_ready), 0);
    check("mid rst period_start", int'(period_start), 0);
    repeat (4) @(negedge clk);
    check("mid rst led held", int'(led), 0);
    reset = 1'b0;
    check_ready(0, 1, "mid rst release wr_ready");
    count_to_ps("mid rst to first period_start");
    measure_here(0, 0, 0, "after rst");
    measure(0, 0, 0, "after rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
